pipe_skid_reg: RTL
==================

# pipe_skid_reg

Two-entry registered pipeline stage with a valid/ready handshake on both sides. It decouples adjacent pipeline stages in the FPGA core (e.g. decode→issue, issue→ALU/LSU). Its registered `in_ready` breaks the combinational ready path between stages, and it sustains one transfer per cycle. Its valid/data flops follow the core's flop-primitive semantics: all state is clocked on `clk`, with no combinational paths from input to output.

## Interface
- `DATA_WIDTH`, 32: payload width in bits; legal range 1..512.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `out_valid`  out  1  downstream payload valid; registered.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_WIDTH  downstream payload; registered.
- `occupancy`  out  2  number of held entries, 0..2.
- `flush`  in  1  synchronous discard; present only with `PIPE_SKID_FLUSH_EN`.

## Operation
- Storage is two entries:
  - main entry (`main_q`, `main_v`), which drives the output;
  - skid entry (`skid_q`, `skid_v`).
- Port mapping: `out_valid` = `main_v`, `out_data` = `main_q`, `in_ready` = !`skid_v`.
- Transfer definitions: accept = `in_valid` & `in_ready`; take = `out_valid` & `out_ready`.
- States are EMPTY (occupancy 0), ONE (1) and FULL (2).
- EMPTY:
  - accept → ONE; `main_q` <= `in_data`.
  - take is impossible.
- ONE:
  - accept & take → ONE; `main_q` <= `in_data`.
  - accept & !take → FULL; `skid_q` <= `in_data`.
  - !accept & take → EMPTY.
  - Neither → hold.
- FULL:
  - `in_ready` = 0, so accept is impossible.
  - take → ONE; `main_q` <= `skid_q`, `skid_v` <= 0.
  - Otherwise hold.
- Ordering is strictly FIFO; no entry is duplicated or dropped.
- Output stability: while `out_valid` & !`out_ready`, `out_data` and `out_valid` hold.
- Data registers update only on the transitions listed above. Otherwise they hold, including stale data while the entry is invalid.
- `in_data` is not inspected when `in_valid` = 0.
- Illegal state (`skid_v` & !`main_v`) is unreachable. If it is forced in simulation, the next edge moves the skid entry to main.

## Timing
- Reset (`rst` = 0 at an edge), which has priority over everything:
  - `main_v` = `skid_v` = 0, so `out_valid` = 0, `in_ready` = 1, `occupancy` = 0.
  - `main_q` = `skid_q` = 0, so `out_data` = 0.
  - The values are visible after that edge.
- Reset mid-operation discards both entries. Any accept in that cycle is lost, and the upstream must not count it as delivered.
- Latency: data accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N (cycle N+1) when the stage was EMPTY, or when ONE with a simultaneous take.
- Throughput is one transfer per cycle when `out_ready` is held at 1.
- `in_ready` depends only on flops. No combinational path exists from `out_ready`, `in_valid` or `in_data` to any output.
- Backpressure: the first cycle `out_ready` = 0 while in ONE with an accept → FULL. `in_ready` drops after that edge. The skid entry absorbs the word already in flight.
- Recovery: take in FULL → `in_ready` = 1 after the edge. The earliest next accept is one cycle later.
- `occupancy` is registered and equals `main_v` + `skid_v` at every cycle.

## Configuration
- `PIPE_SKID_FLUSH_EN` defined:
  - The `flush` port exists.
  - `flush` = 1 at an edge → EMPTY: both valids cleared, data registers hold.
  - Any accept or take in that cycle is discarded.
  - Priority is reset > flush > transfers.
  - `in_ready` after the flush edge = 1.
- `PIPE_SKID_FLUSH_EN` undefined:
  - The `flush` port is absent and there is no flush logic.
  - Behaviour is otherwise identical.

## Test plan
- Reset:
  - Stimulus: hold `rst` = 0 for 3 cycles with `in_valid` = 1, `in_data` = 32'hDEAD_BEEF.
  - Required response: `out_valid` = 0, `in_ready` = 1, `occupancy` = 0, `out_data` = 0.
- Streaming:
  - Stimulus: `out_ready` = 1; drive 0x1..0x8 on consecutive cycles.
  - Required response: `out_data` 0x1..0x8 on consecutive cycles, one cycle behind; `in_ready` is never 0.
- Backpressure:
  - Stimulus: send 0xA, 0xB, 0xC with `out_ready` = 0 from the cycle 0xA is visible.
  - Required response: `occupancy` reaches 2; `in_ready` = 0; 0xC is held upstream.
  - Then raise `out_ready`: outputs 0xA, 0xB, 0xC in order with no loss.
- Random:
  - Stimulus: 10k cycles with random `in_valid` and `out_ready` at 50%.
  - Required response: the scoreboard sees FIFO order; `out_data` is stable while stalled; `occupancy` always equals the model count.
- Mid-operation reset:
  - Stimulus: in FULL holding 0x5, 0x6, assert `rst` = 0 for 1 cycle.
  - Required response: `occupancy` = 0 and `out_valid` = 0 next cycle; 0x5 and 0x6 never appear.
- Flush (`PIPE_SKID_FLUSH_EN` only):
  - Stimulus: in FULL, `flush` = 1 together with `out_ready` = 1.
  - Required response: no take counted; next cycle `occupancy` = 0 and `in_ready` = 1.
  - A following accept of 0x9 appears one cycle later.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry registered pipeline stage with valid/ready on both sides and a registered in_ready.
// Optional synchronous discard port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_reg #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic                  flush,
`endif
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            occupancy
);

   // Encoding is {skid_v, main_v}; 2'b10 is the unreachable skid-without-main state.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_q, main_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic [1:0]            occ_q, occ_d;
   logic                  main_v, skid_v;
   logic                  accept, take;

   assign main_v    = state_q[0];
   assign skid_v    = state_q[1];
   assign in_ready  = !skid_v;
   assign out_valid = main_v;
   assign out_data  = main_q;
   assign occupancy = occ_q;

   assign accept = in_valid & in_ready;
   assign take   = main_v & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (accept && take) begin
               main_d = in_data;
            end else if (accept) begin
               state_d = FULL;
               skid_d  = in_data;
            end else if (take) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (take) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: begin
            // Forced skid-only state: promote the skid word so nothing is lost.
            state_d = ONE;
            main_d  = skid_q;
         end
      endcase
`ifdef PIPE_SKID_FLUSH_EN
      if (flush) begin
         state_d = EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
`endif
      occ_d = {1'b0, state_d[0]} + {1'b0, state_d[1]};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         occ_q   <= occ_d;
      end
   end

endmodule
